// File: rtl/alu_sched_pkg.sv
// Shared definitions for the ALU scheduler: op codes, FSM states, flag bit positions.
package alu_sched_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLL = 3'b100;
  localparam logic [2:0] OP_SRL = 3'b101;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_O = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // 3'b110 and 3'b111 have no ALU meaning.
  function automatic logic is_illegal_op(input logic [2:0] op);
    return op[2:1] == 2'b11;
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU datapath; flags are {Z,N,C,O}, C on SUB means "no borrow".
module alu
  import alu_sched_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       op_i,
  output logic [WIDTH-1:0] result_o,
  output logic [3:0]       flags_o
);

  localparam int SH_W = $clog2(WIDTH);

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic             ovf;

  always_comb begin
    sum   = '0;
    res   = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    case (op_i)
      OP_ADD: begin
        sum   = {1'b0, a_i} + {1'b0, b_i};
        res   = sum[WIDTH-1:0];
        carry = sum[WIDTH];
        ovf   = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (res[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_SUB: begin
        sum   = {1'b0, a_i} + {1'b0, ~b_i} + {{WIDTH{1'b0}}, 1'b1};
        res   = sum[WIDTH-1:0];
        carry = sum[WIDTH];
        ovf   = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (res[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_AND:  res = a_i & b_i;
      OP_OR:   res = a_i | b_i;
      OP_SLL:  res = a_i << b_i[SH_W-1:0];
      OP_SRL:  res = a_i >> b_i[SH_W-1:0];
      default: res = '0;
    endcase
  end

  always_comb begin
    flags_o         = '0;
    flags_o[FLAG_Z] = (res == '0);
    flags_o[FLAG_N] = res[WIDTH-1];
    flags_o[FLAG_C] = carry;
    flags_o[FLAG_O] = ovf;
  end

  assign result_o = res;

endmodule

// File: rtl/alu_sched_rr_pick.sv
// Combinational round-robin picker: first valid at or after the pointer, wrapping.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     valid_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o
);

  always_comb begin
    int   cand;
    logic found;
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = 0;
    for (int i = 0; i < N; i++) begin
      cand = (int'(ptr_i) + i) % N;
      if (!found && valid_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one ALU among NUM_REQ requesters.
// ALU_SCHED_ERR_EN: ops 110/111 bypass the ALU and return an error response one cycle early.
module alu_sched
  import alu_sched_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ*3-1:0]     req_op,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_result,
  output logic [3:0]               rsp_flags,
  output logic                     rsp_err,
  output logic                     busy
);

  // state | meaning
  // IDLE  | arbitrating; grant offered to the RR winner
  // EXEC  | ALU evaluates latched operands; result registered
  // RESP  | response held until rsp_ready

  state_e            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [WIDTH-1:0]  a_q, b_q, result_q;
  logic [2:0]        op_q;
  logic [ID_W-1:0]   id_q;
  logic [3:0]        flags_q;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    win_idx;
  logic [WIDTH-1:0]   a_sel, b_sel, alu_result;
  logic [2:0]         op_sel;
  logic [3:0]         alu_flags;
  logic               accept;
  logic               bypass;

  rr_pick #(.N(NUM_REQ), .IDX_W(ID_W)) u_pick (
    .valid_i (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .idx_o   (win_idx)
  );

  alu #(.WIDTH(WIDTH)) u_alu (
    .a_i      (a_q),
    .b_i      (b_q),
    .op_i     (op_q),
    .result_o (alu_result),
    .flags_o  (alu_flags)
  );

  assign a_sel  = req_a[win_idx*WIDTH +: WIDTH];
  assign b_sel  = req_b[win_idx*WIDTH +: WIDTH];
  assign op_sel = req_op[win_idx*3 +: 3];

`ifdef ALU_SCHED_ERR_EN
  assign bypass = is_illegal_op(op_sel);
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          accept  = 1'b1;
          ptr_d   = (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
          state_d = bypass ? RESP : EXEC;
        end
      end
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      id_q     <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      if (accept) begin
        a_q  <= a_sel;
        b_q  <= b_sel;
        op_q <= op_sel;
        id_q <= win_idx;
      end
      if (state_q == EXEC) begin
        result_q <= alu_result;
        flags_q  <= alu_flags;
      end else if (accept && bypass) begin
        result_q <= '0;
        flags_q  <= '0;
      end
    end
  end

`ifdef ALU_SCHED_ERR_EN
  logic err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= bypass;
    end
  end

  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  assign req_ready  = (state_q == IDLE) ? grant : '0;
  assign rsp_valid  = (state_q == RESP);
  assign rsp_id     = id_q;
  assign rsp_result = result_q;
  assign rsp_flags  = flags_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_sched.sv
// Directed, table-driven bench for alu_sched plus stall, reset-abort and round-robin sequences.
module tb_alu_sched;

  localparam int WIDTH   = 32;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                     clk;
  logic                     rst_n;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ*3-1:0]     req_op;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic [WIDTH-1:0]         rsp_result;
  logic [3:0]               rsp_flags;
  logic                     rsp_err;
  logic                     busy;

  int n_checks = 0;
  int n_fail   = 0;

  alu_sched #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] res;
    logic [3:0]  flags;
    int          lat;
    logic        err;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_slot(input int id, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] op);
    req_a[id*WIDTH +: WIDTH] = a;
    req_b[id*WIDTH +: WIDTH] = b;
    req_op[id*3 +: 3]        = op;
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic do_op(input vec_t v, input int idx);
    logic [3:0] oh;
    int         lat;
    oh = 4'b0001 << v.id;
    req_a = '0; req_b = '0; req_op = '0;
    set_slot(int'(v.id), v.a, v.b, v.op);
    req_valid = oh;
    #1;
    check($sformatf("vec%0d_ready", idx), 64'(req_ready), 64'(oh));
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    lat = 1;
    while (!rsp_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    check($sformatf("vec%0d_latency", idx), 64'(lat), 64'(v.lat));
    check($sformatf("vec%0d_id", idx), 64'(rsp_id), 64'(v.id));
    check($sformatf("vec%0d_result", idx), 64'(rsp_result), 64'(v.res));
    check($sformatf("vec%0d_flags", idx), 64'(rsp_flags), 64'(v.flags));
    check($sformatf("vec%0d_err", idx), 64'(rsp_err), 64'(v.err));
    @(negedge clk);
    check($sformatf("vec%0d_valid_drop", idx), 64'(rsp_valid), 64'd0);
    check($sformatf("vec%0d_idle", idx), 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;

    //            id    a             b             op      res           flags    lat err
    vecs[0]  = '{2'd0, 32'd10,       32'd20,       3'b000, 32'd30,       4'b0000, 2, 1'b0};
    vecs[1]  = '{2'd3, 32'd50,       32'd20,       3'b001, 32'd30,       4'b0010, 2, 1'b0};
    vecs[2]  = '{2'd2, 32'h7FFFFFFF, 32'd1,        3'b000, 32'h80000000, 4'b0101, 2, 1'b0};
    vecs[3]  = '{2'd2, 32'h80000000, 32'd1,        3'b001, 32'h7FFFFFFF, 4'b0011, 2, 1'b0};
    vecs[4]  = '{2'd1, 32'hF0F000FF, 32'h0FF00F0F, 3'b010, 32'h00F0000F, 4'b0000, 2, 1'b0};
    vecs[5]  = '{2'd0, 32'd0,        32'd0,        3'b011, 32'd0,        4'b1000, 2, 1'b0};
    vecs[6]  = '{2'd1, 32'd1,        32'd31,       3'b100, 32'h80000000, 4'b0100, 2, 1'b0};
    vecs[7]  = '{2'd3, 32'h80000000, 32'd4,        3'b101, 32'h08000000, 4'b0000, 2, 1'b0};
    vecs[8]  = '{2'd1, 32'd5,        32'd5,        3'b001, 32'd0,        4'b1010, 2, 1'b0};
    vecs[9]  = '{2'd0, 32'hFFFFFFFF, 32'd1,        3'b000, 32'd0,        4'b1010, 2, 1'b0};
`ifdef ALU_SCHED_ERR_EN
    vecs[10] = '{2'd1, 32'd7,        32'd9,        3'b111, 32'd0,        4'b0000, 1, 1'b1};
    vecs[11] = '{2'd2, 32'd7,        32'd9,        3'b110, 32'd0,        4'b0000, 1, 1'b1};
`else
    vecs[10] = '{2'd1, 32'd7,        32'd9,        3'b111, 32'd0,        4'b1000, 2, 1'b0};
    vecs[11] = '{2'd2, 32'd7,        32'd9,        3'b110, 32'd0,        4'b1000, 2, 1'b0};
`endif

    repeat (2) @(negedge clk);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_id", 64'(rsp_id), 64'd0);
    check("rst_rsp_result", 64'(rsp_result), 64'd0);
    check("rst_rsp_flags", 64'(rsp_flags), 64'd0);
    check("rst_rsp_err", 64'(rsp_err), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) do_op(vecs[i], i);

    // Response stall: other requesters pending while rsp_ready is low.
    rsp_ready = 1'b0;
    req_a = '0; req_b = '0; req_op = '0;
    set_slot(3, 32'd50, 32'd20, 3'b001);
    req_valid = 4'b1000;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) set_slot(i, 32'd1, 32'd1, 3'b000);
    req_valid = 4'b1111;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("stall%0d_valid", k), 64'(rsp_valid), 64'd1);
      check($sformatf("stall%0d_result", k), 64'(rsp_result), 64'd30);
      check($sformatf("stall%0d_flags", k), 64'(rsp_flags), 64'b0010);
      check($sformatf("stall%0d_id", k), 64'(rsp_id), 64'd3);
      check($sformatf("stall%0d_ready", k), 64'(req_ready), 64'd0);
      check($sformatf("stall%0d_busy", k), 64'(busy), 64'd1);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    req_valid = '0;
    @(negedge clk);
    check("stall_release_idle", 64'(busy), 64'd0);

    // Reset during EXEC aborts; after release requester 0 wins first and grants rotate.
    set_slot(0, 32'd1, 32'd2, 3'b000);
    req_valid = 4'b0001;
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    check("abort_in_exec", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_rsp_valid", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    check("abort_rsp_valid_held", 64'(rsp_valid), 64'd0);
    for (int i = 0; i < NUM_REQ; i++) set_slot(i, 32'(i * 100), 32'(i), 3'b000);
    rst_n     = 1'b1;
    req_valid = 4'b1111;
    for (int k = 0; k < 15; k++) begin
      logic [3:0] exp_rdy;
      int         who;
      who     = (k / 3) % NUM_REQ;
      exp_rdy = (k % 3 == 0) ? (4'b0001 << who) : 4'b0000;
      #1;
      check($sformatf("rr%0d_ready", k), 64'(req_ready), 64'(exp_rdy));
      if (k % 3 == 2) begin
        check($sformatf("rr%0d_rsp_valid", k), 64'(rsp_valid), 64'd1);
        check($sformatf("rr%0d_rsp_id", k), 64'(rsp_id), 64'(who));
        check($sformatf("rr%0d_result", k), 64'(rsp_result), 64'(who * 101));
      end
      @(negedge clk);
    end
    req_valid = '0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
